// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with combinational sync, DE and strobe decode.
// Optional frame counter enabled by defining VIDEO_TIMING_FRAME_COUNT_EN.
module video_timing_gen #(
  parameter int unsigned H_TOTAL      = 1024,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 704,
  parameter int unsigned H_SYNC_WIDTH = 96,
  parameter int unsigned V_TOTAL      = 260,
  parameter int unsigned V_ACTIVE     = 200,
  parameter int unsigned V_SYNC_START = 224,
  parameter int unsigned V_SYNC_WIDTH = 8,
  parameter bit          H_SYNC_POL   = 1'b1,
  parameter bit          V_SYNC_POL   = 1'b1,
  localparam int unsigned HW = $clog2(H_TOTAL),
  localparam int unsigned VW = $clog2(V_TOTAL)
) (
  input  logic          clk_16_i,
  input  logic          reset_n_i,
  input  logic          pix_en_i,
  output logic          h_sync_o,
  output logic          v_sync_o,
  output logic          de_o,
  output logic [HW-1:0] col_o,
  output logic [VW-1:0] row_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic [7:0]    frame_count_o
);

  // One extra bit so region end points equal to H_TOTAL/V_TOTAL never wrap.
  localparam int unsigned HE = HW + 1;
  localparam int unsigned VE = VW + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [HE-1:0] H_ACT_E = HE'(H_ACTIVE);
  localparam logic [HE-1:0] H_SS_E  = HE'(H_SYNC_START);
  localparam logic [HE-1:0] H_SE_E  = HE'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [VE-1:0] V_ACT_E = VE'(V_ACTIVE);
  localparam logic [VE-1:0] V_SS_E  = VE'(V_SYNC_START);
  localparam logic [VE-1:0] V_SE_E  = VE'(V_SYNC_START + V_SYNC_WIDTH);

  if (H_TOTAL < 2 || H_SYNC_WIDTH < 1 || H_ACTIVE > H_SYNC_START ||
      H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_bad_h_timing
    $error("video_timing_gen: illegal horizontal timing parameters");
  end

  if (V_TOTAL < 2 || V_SYNC_WIDTH < 1 || V_ACTIVE > V_SYNC_START ||
      V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_bad_v_timing
    $error("video_timing_gen: illegal vertical timing parameters");
  end

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_count == H_LAST);
  assign v_last = (v_count == V_LAST);

  // Raster position; only advances on enabled pixel slots.
  always_ff @(posedge clk_16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_en_i) begin
      if (h_last) begin
        h_count <= '0;
        v_count <= v_last ? '0 : v_count + VW'(1);
      end else begin
        h_count <= h_count + HW'(1);
      end
    end
  end

  logic [HE-1:0] h_ext;
  logic [VE-1:0] v_ext;
  logic          h_in_sync;
  logic          v_in_sync;

  assign h_ext = HE'(h_count);
  assign v_ext = VE'(v_count);

  // Zero-latency decode straight off the counter registers.
  always_comb begin
    h_in_sync = (h_ext >= H_SS_E) && (h_ext < H_SE_E);
    v_in_sync = (v_ext >= V_SS_E) && (v_ext < V_SE_E);
    h_sync_o  = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_o  = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
    de_o      = (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
  end

  assign col_o         = h_count;
  assign row_o         = v_count;
  assign line_start_o  = pix_en_i && (h_count == '0);
  assign frame_start_o = line_start_o && (v_count == '0);

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_count;

  // Counts completed frames, i.e. wraps from the last slot back to (0,0).
  always_ff @(posedge clk_16_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frame_count <= '0;
    end else if (pix_en_i && h_last && v_last) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  assign frame_count_o = frame_count;
`else
  assign frame_count_o = 8'd0;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL provide parameter H_TOTAL, default 1024: pixel slots per line, must be at least 2.
REQ-002 SHALL provide parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 SHALL provide parameter H_SYNC_START, default 704: first h_count of horizontal sync.
REQ-004 SHALL provide parameter H_SYNC_WIDTH, default 96: horizontal sync length in pixel slots.
REQ-005 SHALL provide parameter V_TOTAL, default 260: lines per frame, must be at least 2.
REQ-006 SHALL provide parameter V_ACTIVE, default 200: visible lines per frame.
REQ-007 SHALL provide parameter V_SYNC_START, default 224: first v_count of vertical sync.
REQ-008 SHALL provide parameter V_SYNC_WIDTH, default 8: vertical sync length in lines.
REQ-009 SHALL provide parameter H_SYNC_POL / V_SYNC_POL, default 1 / 1: asserted sync level.
REQ-010 SHALL provide clk_16_i, input, 1: 16 MHz system clock; one clock, all flops on its rising edge.
REQ-011 SHALL provide reset_n_i, input, 1: reset, asynchronous, active-low.
REQ-012 SHALL provide pix_en_i, input, 1: pixel-slot enable; counters advance only when high.
REQ-013 SHALL provide h_sync_o / v_sync_o, output, 1 each: sync outputs at configured polarity.
REQ-014 SHALL provide de_o, output, 1: display enable, high inside the active region.
REQ-015 SHALL provide col_o, output, HW=$clog2(H_TOTAL): current h_count.
REQ-016 SHALL provide row_o, output, VW=$clog2(V_TOTAL): current v_count.
REQ-017 SHALL provide line_start_o / frame_start_o, output, 1 each: single-cycle strobes.
REQ-018 SHALL provide frame_count_o, output, 8: frame counter (see Configuration).

Function
REQ-019 SHALL fail elaboration unless H_ACTIVE <= H_SYNC_START, H_SYNC_START+H_SYNC_WIDTH <= H_TOTAL, H_SYNC_WIDTH >= 1; same rules for V_*.
REQ-020 SHALL increment h_count on each clk_16_i edge with pix_en_i=1; at H_TOTAL-1 wrap to 0.
REQ-021 SHALL increment v_count only when h_count wraps; at V_TOTAL-1 with h wrap, wrap to 0.
REQ-022 SHALL hold both counters unchanged while pix_en_i=0, for any duration.
REQ-023 SHALL decode outputs combinationally from the counter registers (zero latency, no gating by pix_en_i except strobes).
REQ-024 SHALL assert h_sync_o = H_SYNC_POL when H_SYNC_START <= h_count < H_SYNC_START+H_SYNC_WIDTH, else inverted.
REQ-025 SHALL assert v_sync_o = V_SYNC_POL when V_SYNC_START <= v_count < V_SYNC_START+V_SYNC_WIDTH, else inverted; line-granular, changes only at h_count 0.
REQ-026 SHALL drive de_o = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
REQ-027 SHALL drive line_start_o = pix_en_i && h_count==0; frame_start_o = line_start_o && v_count==0.
REQ-028 SHALL hold col_o/row_o at their last values while pix_en_i=0; comparisons SHALL be unsigned at HW/VW bits with no overflow.

Reset
REQ-029 SHALL clear h_count, v_count, frame_count to 0 immediately on reset_n_i low, independent of clock.
REQ-030 SHALL, during and after reset, present outputs decoded from count (0,0): de_o=1 if H_ACTIVE,V_ACTIVE>0; syncs deasserted with defaults; strobes follow pix_en_i.
REQ-031 SHALL restart the frame from (0,0) when reset asserts mid-line or mid-frame; first pix_en_i after release yields frame_start_o.

Configuration
REQ-032 SHALL, with VIDEO_TIMING_FRAME_COUNT_EN defined, increment frame_count_o modulo 256 on every transition from (H_TOTAL-1,V_TOTAL-1) to (0,0).
REQ-033 SHALL, without VIDEO_TIMING_FRAME_COUNT_EN, keep port frame_count_o and tie it to 0, with no counter flops.

Verification
REQ-034 SHALL cover defaults, pix_en_i=1: h_sync_o high for clk 704..799 of each 1024; v_sync_o high lines 224..231; frame = 266240 clk (~60.1 Hz).
REQ-035 SHALL cover pix_en_i 1-in-2: line period 2048 clk; counters hold on idle cycles; line_start_o pulses once per line, 1 clk wide.
REQ-036 SHALL cover H_TOTAL=10,H_ACTIVE=4,H_SYNC_START=5,H_SYNC_WIDTH=5,V_TOTAL=3: h_sync_o high through h_count 9; wrap 9->0 advances row 2->0 with frame_start_o.
REQ-037 SHALL cover reset_n_i low asynchronously at (500,150): col_o,row_o read 0 before the next clock edge; frame restarts.
REQ-038 SHALL cover VIDEO_TIMING_FRAME_COUNT_EN, 257 frames: frame_count_o reads 1; without macro stays 0.
REQ-039 SHALL cover V_SYNC_POL=0: v_sync_o low exactly for lines 224..231, high otherwise.
